// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the pipelined CPU issue/forwarding logic.
//   CPU_XLEN / CPU_RA_W : default datapath and register-address widths
//   slot_t              : one in-flight instruction in the scoreboard
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int CPU_XLEN = 32;
  localparam int CPU_RA_W = 5;

  // data holds the captured result once the slot has moved past the point
  // where its result is produced (alu_result in slot 0, ld_data in LOAD_LAT).
  typedef struct packed {
    logic                valid;
    logic [CPU_RA_W-1:0] rd;
    logic                wen;
    logic                is_load;
    logic [CPU_XLEN-1:0] data;
  } slot_t;

endpackage

// File: rtl/fwd_select.sv
// -----------------------------------------------------------------------------
// fwd_select
// Priority match of one source register against all in-flight slots.
//   rs, rs_used  : source register and whether it is actually read
//   cand         : per-slot "valid and writes rd"
//   slot_rd      : per-slot destination register
//   slot_data    : per-slot effective result
//   slot_dvalid  : per-slot "result is available now"
//   hit          : some slot matches
//   data         : result of the youngest matching slot
//   ready        : 0 when the youngest match has no result yet
// -----------------------------------------------------------------------------
module fwd_select #(
  parameter int XLEN   = 32,
  parameter int RA_W   = 5,
  parameter int STAGES = 2
) (
  input  logic [RA_W-1:0]   rs,
  input  logic              rs_used,
  input  logic [STAGES-1:0] cand,
  input  logic [RA_W-1:0]   slot_rd     [STAGES],
  input  logic [XLEN-1:0]   slot_data   [STAGES],
  input  logic [STAGES-1:0] slot_dvalid,
  output logic              hit,
  output logic [XLEN-1:0]   data,
  output logic              ready
);

  // Walk from oldest to youngest so the lowest-index match overrides.
  always_comb begin
    hit   = 1'b0;
    data  = '0;
    ready = 1'b1;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (cand[k] && rs_used && (rs != '0) && (slot_rd[k] == rs)) begin
        hit   = 1'b1;
        data  = slot_data[k];
        ready = slot_dvalid[k];
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_fwd.sv
// -----------------------------------------------------------------------------
// pipe_hazard_fwd
// Operand issue, in-flight tracking and result forwarding between decode and
// register-file write-back. Slot 0 is EX (youngest), slot STAGES-1 is WB.
//   clk, reset                 : clock, synchronous active-high reset
//   iss_*                      : decoded instruction and its handshake
//   rf_rdata1/2                : register-file read data for iss_rs1/2
//   ex_op1/2, ex_valid         : registered operands for the slot-0 ALU op
//   alu_result                 : ALU output for slot 0
//   ld_data                    : load data for the load in slot LOAD_LAT
//   wb_en, wb_rd, wb_data      : register-file write port (oldest slot)
//   stall_cnt                  : saturating count of stalled issue cycles
// STAGES=1 makes slot 0 the write-back slot and requires LOAD_LAT=0.
// -----------------------------------------------------------------------------
module pipe_hazard_fwd
  import cpu_pkg::*;
#(
  parameter int XLEN     = CPU_XLEN,
  parameter int RA_W     = CPU_RA_W,
  parameter int STAGES   = 2,
  parameter int LOAD_LAT = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            iss_valid,
  output logic            iss_ready,
  input  logic [RA_W-1:0] iss_rs1,
  input  logic [RA_W-1:0] iss_rs2,
  input  logic [RA_W-1:0] iss_rd,
  input  logic            iss_rs1_used,
  input  logic            iss_rs2_used,
  input  logic            iss_wen,
  input  logic            iss_is_load,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  output logic [XLEN-1:0] ex_op1,
  output logic [XLEN-1:0] ex_op2,
  output logic            ex_valid,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] ld_data,
  output logic            wb_en,
  output logic [RA_W-1:0] wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic [31:0]     stall_cnt
);

  slot_t             slot_reg [STAGES];
  logic [XLEN-1:0]   eff_data [STAGES];
  logic [RA_W-1:0]   slot_rd  [STAGES];
  logic [STAGES-1:0] dvalid;
  logic [STAGES-1:0] cand;

  logic [XLEN-1:0]   ex_op1_reg, ex_op2_reg;
  logic [31:0]       stall_cnt_reg;

  // Effective result per slot: live ALU output in slot 0, live load data at
  // LOAD_LAT, otherwise whatever was captured while shifting.
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_slot
    assign eff_data[gi] = (gi == 0 && !slot_reg[gi].is_load)        ? alu_result :
                          (gi == LOAD_LAT && slot_reg[gi].is_load)  ? ld_data    :
                                                                      slot_reg[gi].data;
    assign dvalid[gi]   = !slot_reg[gi].is_load || (gi >= LOAD_LAT);
    assign cand[gi]     = slot_reg[gi].valid && slot_reg[gi].wen;
    assign slot_rd[gi]  = slot_reg[gi].rd;
  end

  logic            hit1, hit2, rdy1, rdy2;
  logic [XLEN-1:0] fwd1, fwd2;

  fwd_select #(.XLEN(XLEN), .RA_W(RA_W), .STAGES(STAGES)) u_fwd_rs1 (
    .rs          (iss_rs1),
    .rs_used     (iss_rs1_used),
    .cand        (cand),
    .slot_rd     (slot_rd),
    .slot_data   (eff_data),
    .slot_dvalid (dvalid),
    .hit         (hit1),
    .data        (fwd1),
    .ready       (rdy1)
  );

  fwd_select #(.XLEN(XLEN), .RA_W(RA_W), .STAGES(STAGES)) u_fwd_rs2 (
    .rs          (iss_rs2),
    .rs_used     (iss_rs2_used),
    .cand        (cand),
    .slot_rd     (slot_rd),
    .slot_data   (eff_data),
    .slot_dvalid (dvalid),
    .hit         (hit2),
    .data        (fwd2),
    .ready       (rdy2)
  );

  logic            hazard, issue, stall;
  logic [XLEN-1:0] op1_next, op2_next;

  assign hazard    = !rdy1 || !rdy2;
  assign iss_ready = !(iss_valid && hazard);
  assign issue     = iss_valid && iss_ready;
  assign stall     = iss_valid && !iss_ready;

  // x0 always reads as zero, even if an in-flight slot names it.
  assign op1_next = (iss_rs1 == '0) ? '0 : (hit1 ? fwd1 : rf_rdata1);
  assign op2_next = (iss_rs2 == '0) ? '0 : (hit2 ? fwd2 : rf_rdata2);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) slot_reg[k] <= '0;
      ex_op1_reg    <= '0;
      ex_op2_reg    <= '0;
      stall_cnt_reg <= '0;
    end else begin
      for (int k = 1; k < STAGES; k++) begin
        slot_reg[k]      <= slot_reg[k-1];
        slot_reg[k].data <= eff_data[k-1];
      end
      if (issue) begin
        slot_reg[0] <= '{valid: 1'b1, rd: iss_rd, wen: iss_wen,
                         is_load: iss_is_load, data: '0};
        ex_op1_reg  <= op1_next;
        ex_op2_reg  <= op2_next;
      end else begin
        slot_reg[0] <= '0;
      end
      if (stall && (stall_cnt_reg != 32'hFFFF_FFFF))
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign ex_op1    = ex_op1_reg;
  assign ex_op2    = ex_op2_reg;
  assign ex_valid  = slot_reg[0].valid;
  assign stall_cnt = stall_cnt_reg;

  // In a reset cycle the in-flight work is being discarded, so suppress the
  // write that the oldest slot would otherwise perform.
  assign wb_en   = slot_reg[STAGES-1].valid && slot_reg[STAGES-1].wen &&
                   (slot_reg[STAGES-1].rd != '0) && !reset;
  assign wb_rd   = slot_reg[STAGES-1].valid ? slot_reg[STAGES-1].rd : '0;
  assign wb_data = slot_reg[STAGES-1].valid ? eff_data[STAGES-1] : '0;

endmodule

// File: tb/tb_pipe_hazard_fwd.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_fwd
// Scoreboard bench for pipe_hazard_fwd (STAGES=2, LOAD_LAT=1). Expected
// operands and write-backs are queued when an instruction is issued and
// popped when the DUT presents ex_valid / wb_en.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_fwd;

  logic        clk = 1'b0;
  logic        reset;
  logic        iss_valid, iss_ready;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd;
  logic        iss_rs1_used, iss_rs2_used, iss_wen, iss_is_load;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic [31:0] ex_op1, ex_op2;
  logic        ex_valid;
  logic [31:0] alu_result, ld_data;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] stall_cnt;

  pipe_hazard_fwd #(.XLEN(32), .RA_W(5), .STAGES(2), .LOAD_LAT(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .iss_valid    (iss_valid),
    .iss_ready    (iss_ready),
    .iss_rs1      (iss_rs1),
    .iss_rs2      (iss_rs2),
    .iss_rd       (iss_rd),
    .iss_rs1_used (iss_rs1_used),
    .iss_rs2_used (iss_rs2_used),
    .iss_wen      (iss_wen),
    .iss_is_load  (iss_is_load),
    .rf_rdata1    (rf_rdata1),
    .rf_rdata2    (rf_rdata2),
    .ex_op1       (ex_op1),
    .ex_op2       (ex_op2),
    .ex_valid     (ex_valid),
    .alu_result   (alu_result),
    .ld_data      (ld_data),
    .wb_en        (wb_en),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
  } pair_t;

  pair_t exq[$];
  pair_t wbq[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic expect_ex(input logic [31:0] op1, input logic [31:0] op2);
    pair_t p;
    p.a = op1;
    p.b = op2;
    exq.push_back(p);
  endtask

  task automatic expect_wb(input logic [31:0] rd, input logic [31:0] data);
    pair_t p;
    p.a = rd;
    p.b = data;
    wbq.push_back(p);
  endtask

  // One clock cycle: wait for the edge, drive this cycle's inputs, let them
  // settle, then check iss_ready and service the scoreboard.
  task automatic cyc(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic u1, input logic u2,
                     input logic wen, input logic ld,
                     input logic [31:0] rf1, input logic [31:0] rf2,
                     input logic [31:0] alu, input logic [31:0] ldd,
                     input logic exp_rdy);
    pair_t p;
    @(posedge clk);
    #1;
    reset        = 1'b0;
    iss_valid    = v;
    iss_rs1      = rs1;
    iss_rs2      = rs2;
    iss_rd       = rd;
    iss_rs1_used = u1;
    iss_rs2_used = u2;
    iss_wen      = wen;
    iss_is_load  = ld;
    rf_rdata1    = rf1;
    rf_rdata2    = rf2;
    alu_result   = alu;
    ld_data      = ldd;
    #1;
    check("iss_ready", 32'(iss_ready), 32'(exp_rdy));
    if (ex_valid) begin
      check("ex_pending", 32'(exq.size() > 0), 32'd1);
      if (exq.size() > 0) begin
        p = exq.pop_front();
        check("ex_op1", ex_op1, p.a);
        check("ex_op2", ex_op2, p.b);
      end
    end
    if (wb_en) begin
      check("wb_pending", 32'(wbq.size() > 0), 32'd1);
      if (wbq.size() > 0) begin
        p = wbq.pop_front();
        check("wb_rd", 32'(wb_rd), p.a);
        check("wb_data", wb_data, p.b);
      end
    end
    $display("cyc t=%0t v=%0b rdy=%0b exv=%0b op1=%08h op2=%08h wb=%0b rd=%0d data=%08h stall=%08h",
             $time, v, iss_ready, ex_valid, ex_op1, ex_op2, wb_en, wb_rd, wb_data, stall_cnt);
  endtask

  task automatic idle(input logic [31:0] alu, input logic [31:0] ldd);
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, alu, ldd, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    iss_valid    = 1'b0;
    iss_rs1      = '0;
    iss_rs2      = '0;
    iss_rd       = '0;
    iss_rs1_used = 1'b0;
    iss_rs2_used = 1'b0;
    iss_wen      = 1'b0;
    iss_is_load  = 1'b0;
    rf_rdata1    = '0;
    rf_rdata2    = '0;
    alu_result   = '0;
    ld_data      = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst_ex_valid", 32'(ex_valid), 32'd0);
    check("rst_ex_op1", ex_op1, 32'd0);
    check("rst_ex_op2", ex_op2, 32'd0);
    check("rst_wb_en", 32'(wb_en), 32'd0);
    check("rst_wb_rd", 32'(wb_rd), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_stall_cnt", stall_cnt, 32'd0);
    check("rst_iss_ready", 32'(iss_ready), 32'd1);

    // Back-to-back dependent ALU ops: x1=5 then read x1.
    expect_ex(32'd0, 32'd0); expect_wb(32'd1, 32'd5);
    cyc(1, 5'd0, 5'd0, 5'd1, 0, 0, 1, 0, 32'd0, 32'd0, 32'd0, 32'd0, 1);
    expect_ex(32'd5, 32'h222); expect_wb(32'd4, 32'h20);
    cyc(1, 5'd1, 5'd9, 5'd4, 1, 0, 1, 0, 32'h111, 32'h222, 32'd5, 32'd0, 1);
    check("no_stall", stall_cnt, 32'd0);
    idle(32'h20, 32'd0);
    idle(32'd0, 32'd0);

    // Load-use: one stall cycle, then forward ld_data.
    expect_ex(32'd0, 32'd0); expect_wb(32'd2, 32'hDEADBEEF);
    cyc(1, 5'd0, 5'd0, 5'd2, 0, 0, 1, 1, 32'd0, 32'd0, 32'd0, 32'd0, 1);
    cyc(1, 5'd2, 5'd0, 5'd5, 1, 0, 1, 0, 32'h333, 32'd0, 32'd0, 32'd0, 0);
    expect_ex(32'hDEADBEEF, 32'd0); expect_wb(32'd5, 32'h77);
    cyc(1, 5'd2, 5'd0, 5'd5, 1, 0, 1, 0, 32'h333, 32'd0, 32'd0, 32'hDEADBEEF, 1);
    check("ld_use_stall_cnt", stall_cnt, 32'd1);
    idle(32'h77, 32'd0);
    idle(32'd0, 32'd0);

    // Two writes to x3 in flight: the younger (9) must be forwarded.
    expect_ex(32'd0, 32'd0); expect_wb(32'd3, 32'd7);
    cyc(1, 5'd0, 5'd0, 5'd3, 0, 0, 1, 0, 32'd0, 32'd0, 32'd0, 32'd0, 1);
    expect_ex(32'd0, 32'd0); expect_wb(32'd3, 32'd9);
    cyc(1, 5'd0, 5'd0, 5'd3, 0, 0, 1, 0, 32'd0, 32'd0, 32'd7, 32'd0, 1);
    expect_ex(32'd9, 32'd9); expect_wb(32'd6, 32'h66);
    cyc(1, 5'd3, 5'd3, 5'd6, 1, 1, 1, 0, 32'hAAA, 32'hBBB, 32'd9, 32'd0, 1);
    idle(32'h66, 32'd0);
    idle(32'd0, 32'd0);

    // Write to x0 never writes back; reading x0 yields 0.
    expect_ex(32'd0, 32'd0);
    cyc(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 32'd0, 32'd0, 32'd0, 32'd0, 1);
    expect_ex(32'd0, 32'd0); expect_wb(32'd7, 32'h10);
    cyc(1, 5'd0, 5'd0, 5'd7, 1, 1, 1, 0, 32'h1234, 32'h5678, 32'h55, 32'd0, 1);
    idle(32'h10, 32'd0);
    check("x0_wb_en", 32'(wb_en), 32'd0);
    idle(32'd0, 32'd0);

    // Reset during a load-use stall discards everything in flight.
    expect_ex(32'd0, 32'd0);
    cyc(1, 5'd0, 5'd0, 5'd8, 0, 0, 1, 1, 32'd0, 32'd0, 32'd0, 32'd0, 1);
    cyc(1, 5'd8, 5'd0, 5'd9, 1, 0, 1, 0, 32'h999, 32'd0, 32'd0, 32'd0, 0);
    reset = 1'b1;
    expect_ex(32'h999, 32'd0); expect_wb(32'd9, 32'h31);
    cyc(1, 5'd8, 5'd0, 5'd9, 1, 0, 1, 0, 32'h999, 32'd0, 32'd0, 32'd0, 1);
    check("mid_rst_ex_valid", 32'(ex_valid), 32'd0);
    check("mid_rst_wb_en", 32'(wb_en), 32'd0);
    check("mid_rst_stall_cnt", stall_cnt, 32'd0);
    idle(32'h31, 32'd0);
    idle(32'd0, 32'd0);

    // Saturation: preload the counter just below the top, then stall twice.
    expect_ex(32'd0, 32'd0); expect_wb(32'd10, 32'hA0A0);
    cyc(1, 5'd0, 5'd0, 5'd10, 0, 0, 1, 1, 32'd0, 32'd0, 32'd0, 32'd0, 1);
    cyc(1, 5'd10, 5'd0, 5'd11, 1, 0, 1, 1, 32'd0, 32'd0, 32'd0, 32'd0, 0);
    force dut.stall_cnt_reg = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_reg;
    expect_ex(32'hA0A0, 32'd0); expect_wb(32'd11, 32'hB0B0);
    cyc(1, 5'd10, 5'd0, 5'd11, 1, 0, 1, 1, 32'd0, 32'd0, 32'd0, 32'hA0A0, 1);
    check("sat_reach", stall_cnt, 32'hFFFF_FFFF);
    cyc(1, 5'd11, 5'd0, 5'd12, 1, 0, 1, 0, 32'd0, 32'd0, 32'd0, 32'd0, 0);
    expect_ex(32'hB0B0, 32'd0); expect_wb(32'd12, 32'h1C);
    cyc(1, 5'd11, 5'd0, 5'd12, 1, 0, 1, 0, 32'd0, 32'd0, 32'd0, 32'hB0B0, 1);
    check("sat_hold", stall_cnt, 32'hFFFF_FFFF);
    idle(32'h1C, 32'd0);
    idle(32'd0, 32'd0);
    idle(32'd0, 32'd0);

    check("exq_drained", 32'(exq.size()), 32'd0);
    check("wbq_drained", 32'(wbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
